// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and defaults for the adder sequencing controller.
// Holds the FSM state encoding and default parameter values.
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_ADD  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_DEBOUNCE_CYC = 500000;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand/result bus between the controller and the external adder.
// master: drives op_a/op_b, reads sum_in/cout_in; slave: the adder side.
interface adder_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;

    modport master (
        output op_a,
        output op_b,
        input  sum_in,
        input  cout_in
    );

    modport slave (
        input  op_a,
        input  op_b,
        output sum_in,
        output cout_in
    );
endinterface

// File: rtl/adder_seq_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, press pulse.
// Ports: clk, rst_n, key_n (async, active-low) -> press (1-cycle, on debounced fall).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] != level) begin
                if (cnt == LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                    // pulse only when the accepted level becomes pressed
                    press <= ~sync[1];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencing controller for the shared ripple adder: loads A then B on presses.
// Ports: CLOCK_50, resetn, key_n, sw_data, adder bus (master), result, carry, state, done.
// Optional: define ADDER_ACCUM_EN for running accumulation with sticky carry.
module adder_seq_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             key_n,
    input  logic [WIDTH-1:0] sw_data,
    adder_seq_ctrl_if.master adder,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [1:0]       state,
    output logic             done
);
    state_t st;
    logic   press;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
        .clk  (CLOCK_50),
        .rst_n(resetn),
        .key_n(key_n),
        .press(press)
    );

    assign state = st;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            st         <= S_A;
            adder.op_a <= '0;
            adder.op_b <= '0;
            result     <= '0;
            carry      <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (st)
                S_A: begin
                    if (press) begin
                        adder.op_a <= sw_data;
                        st         <= S_B;
                    end
                end
                S_B: begin
                    if (press) begin
                        adder.op_b <= sw_data;
                        st         <= S_ADD;
                    end
                end
                S_ADD: begin
                    // operands settled last cycle, so the adder output is valid
                    result <= adder.sum_in;
`ifdef ADDER_ACCUM_EN
                    carry  <= carry | adder.cout_in;
`else
                    carry  <= adder.cout_in;
`endif
                    st     <= S_DONE;
                    done   <= 1'b1;
                end
                S_DONE: begin
                    if (press) begin
`ifdef ADDER_ACCUM_EN
                        adder.op_a <= result;
                        adder.op_b <= sw_data;
                        st         <= S_ADD;
`else
                        adder.op_a <= sw_data;
                        adder.op_b <= '0;
                        result     <= '0;
                        carry      <= 1'b0;
                        st         <= S_B;
`endif
                        done       <= 1'b0;
                    end
                end
                default: begin
                    st   <= S_A;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl with a behavioural press-level model.
// Works with or without ADDER_ACCUM_EN defined.
module tb_adder_seq_ctrl;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       key_n = 1'b1;
    logic [7:0] sw_data = 8'h00;
    logic [7:0] result;
    logic       carry;
    logic [1:0] state;
    logic       done;

    int checks = 0;
    int errors = 0;

    adder_seq_ctrl_if #(.WIDTH(8)) bus ();

    // external adder beside the controller
    assign {bus.cout_in, bus.sum_in} = {1'b0, bus.op_a} + {1'b0, bus.op_b};

    adder_seq_ctrl #(
        .WIDTH(8),
        .DEBOUNCE_CYC(4)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (resetn),
        .key_n   (key_n),
        .sw_data (sw_data),
        .adder   (bus),
        .result  (result),
        .carry   (carry),
        .state   (state),
        .done    (done)
    );

    always #5 clk = ~clk;

    // reference model: operand/result registers after each accepted press
    logic [7:0] m_a, m_b, m_r;
    logic       m_c;
    int         m_st;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_a  = 8'h00;
        m_b  = 8'h00;
        m_r  = 8'h00;
        m_c  = 1'b0;
        m_st = 0;
        exp_q.delete();
    endfunction

    function automatic void model_add();
        int s;
        s   = int'(m_a) + int'(m_b);
        m_r = 8'(s);
`ifdef ADDER_ACCUM_EN
        m_c = m_c | (s > 255);
`else
        m_c = (s > 255);
`endif
        m_st = 3;
        exp_q.push_back({m_c, m_r});
    endfunction

    function automatic void model_press(input logic [7:0] v);
        case (m_st)
            0: begin
                m_a  = v;
                m_st = 1;
            end
            1: begin
                m_b = v;
                model_add();
            end
            3: begin
`ifdef ADDER_ACCUM_EN
                m_a = m_r;
                m_b = v;
                model_add();
`else
                m_a  = v;
                m_b  = 8'h00;
                m_r  = 8'h00;
                m_c  = 1'b0;
                m_st = 1;
`endif
            end
            default: ;
        endcase
    endfunction

    // monitor: every new result presentation is checked against the queue
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: result %0h carry %0b", result, carry);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("sb_result", int'(result), int'(e[7:0]));
                chk("sb_carry", int'(carry), int'(e[8]));
            end
        end
        done_d <= done;
    end

    task automatic do_reset();
        key_n  = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] v);
        logic [1:0] prev;
        bit         seen;
        sw_data = v;
        prev    = state;
        key_n   = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (state != prev) seen = 1'b1;
        end
        model_press(v);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL press_timeout: state %0d stayed %0d", state, prev);
        end
        if (seen && state == 2'b10) begin
            @(negedge clk);
            chk("add_latency_state", int'(state), 3);
        end
        chk("op_a", int'(bus.op_a), int'(m_a));
        chk("op_b", int'(bus.op_b), int'(m_b));
        chk("state", int'(state), m_st);
        // switches moving while held must not disturb the operands
        sw_data = 8'($urandom);
        repeat (4) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_op_a", int'(bus.op_a), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_done", int'(done), 0);
        resetn = 1'b1;
        @(negedge clk);

        // basic add
        press(8'h12);
        press(8'h34);
        repeat (2) @(negedge clk);
        chk("t1_result", int'(result), 8'h46);
        chk("t1_carry", int'(carry), 0);
        chk("t1_done", int'(done), 1);
        chk("t1_state", int'(state), 3);

        // press from the done state
        press(8'h10);
        repeat (2) @(negedge clk);
`ifdef ADDER_ACCUM_EN
        chk("t5_result", int'(result), 8'h56);
        chk("t5_state", int'(state), 3);
`else
        chk("t5_op_a", int'(bus.op_a), 8'h10);
        chk("t5_op_b", int'(bus.op_b), 8'h00);
        chk("t5_result", int'(result), 8'h00);
        chk("t5_state", int'(state), 1);
`endif

        // overflow only on carry
        do_reset();
        press(8'hFF);
        press(8'h01);
        repeat (2) @(negedge clk);
        chk("t2_result", int'(result), 8'h00);
        chk("t2_carry", int'(carry), 1);

`ifdef ADDER_ACCUM_EN
        do_reset();
        press(8'h80);
        press(8'h80);
        repeat (2) @(negedge clk);
        chk("t6_carry1", int'(carry), 1);
        press(8'h01);
        repeat (2) @(negedge clk);
        chk("t6_result", int'(result), 8'h01);
        chk("t6_carry2", int'(carry), 1);
`endif

        // bounces shorter than the debounce window
        do_reset();
        sw_data = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            key_n = 1'b0;
            repeat (2) @(negedge clk);
            key_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("t3_glitch_state", int'(state), 0);
        chk("t3_glitch_op_a", int'(bus.op_a), 0);
        key_n = 1'b0;
        model_press(8'hA5);
        repeat (10) @(negedge clk);
        chk("t3_steady_state", int'(state), 1);
        chk("t3_steady_op_a", int'(bus.op_a), 8'hA5);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        sw_data = 8'h3C;
        key_n   = 1'b0;
        model_press(8'h3C);
        repeat (100) @(negedge clk);
        chk("t3_hold_state", int'(state), m_st);
        chk("t3_hold_op_b", int'(bus.op_b), 8'h3C);
        key_n = 1'b1;
        repeat (10) @(negedge clk);

        // asynchronous reset mid-sequence
        do_reset();
        press(8'h55);
        chk("t4_pre_op_a", int'(bus.op_a), 8'h55);
        resetn = 1'b0;
        #1;
        chk("t4_state", int'(state), 0);
        chk("t4_op_a", int'(bus.op_a), 0);
        chk("t4_op_b", int'(bus.op_b), 0);
        chk("t4_result", int'(result), 0);
        chk("t4_carry", int'(carry), 0);
        chk("t4_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // random sequences
        for (int i = 0; i < 30; i++) begin
            press(8'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: checks %0d", checks);
        $fatal(1, "timeout");
    end
endmodule
